// File: rtl/entropy_coder_manager_fsm.sv
// Entropy coder manager: schedules quantized 8x8 blocks from the quantizer
// output ring into the run-length/Huffman coder in zigzag order.
// Optional restart-interval handling is compiled in with ENTROPY_RESTART_INTERVAL_EN.
`timescale 1ns/1ps

module entropy_coder_manager_fsm #(
  parameter int unsigned NUM_BUFFERS      = 4,
  parameter int unsigned LUMA_BLOCKS      = 4,
`ifdef ENTROPY_RESTART_INTERVAL_EN
  parameter int unsigned RESTART_INTERVAL = 16,
`endif
  parameter int unsigned CHROMA_BLOCKS    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       quantizer_block_done,
  input  logic       encoder_ready,
  input  logic       encoder_block_done,
  output logic       quantizer_stall,
  output logic [7:0] coefficient_address,
  output logic [1:0] encoder_readbuf,
  output logic       coefficient_valid,
  output logic       coefficient_first,
  output logic       coefficient_last,
  output logic [1:0] component,
`ifdef ENTROPY_RESTART_INTERVAL_EN
  input  logic       restart_done,
  output logic       restart_request,
`endif
  output logic       overflow_error
);

  localparam logic [2:0] FULL_LEVEL = 3'(NUM_BUFFERS);
  localparam logic [1:0] PTR_MASK   = 2'(NUM_BUFFERS - 1);
  localparam logic [3:0] LAST_IDX   = 4'(LUMA_BLOCKS + CHROMA_BLOCKS - 1);
  localparam logic [3:0] LUMA_END   = 4'(LUMA_BLOCKS);
  localparam logic [3:0] CB_END     = 4'(LUMA_BLOCKS + CHROMA_BLOCKS / 2);

  // Zigzag scan position -> natural (row-major) coefficient index.
  localparam logic [5:0] ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDrain
`ifdef ENTROPY_RESTART_INTERVAL_EN
    , StRestart
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] occupancy_q, occupancy_d;
  logic [5:0] counter_q, counter_d;
  logic [1:0] readbuf_q, readbuf_d;
  logic [3:0] block_idx_q, block_idx_d;
  logic       overflow_q, overflow_d;
  logic       valid_q, first_q, last_q;

  logic       issue;
  logic       release_blk;
  logic       full;
  logic       accept;
  logic       last_in_mcu;

`ifdef ENTROPY_RESTART_INTERVAL_EN
  localparam int unsigned MCU_W = (RESTART_INTERVAL > 1) ? $clog2(RESTART_INTERVAL) : 1;
  logic [MCU_W-1:0] mcu_cnt_q, mcu_cnt_d;
  logic             interval_end;
  assign interval_end = (mcu_cnt_q == MCU_W'(RESTART_INTERVAL - 1));
`endif

  assign issue       = (state_q == StSend) && encoder_ready;
  assign release_blk = (state_q == StDrain) && encoder_block_done;
  assign full        = (occupancy_q == FULL_LEVEL);
  // A new block is only absorbed if a slot exists or one frees this very cycle.
  assign accept      = quantizer_block_done && (!full || release_blk);
  assign last_in_mcu = (block_idx_q == LAST_IDX);

  // Ring occupancy and sticky overflow next-state.
  always_comb begin
    occupancy_d = occupancy_q;
    overflow_d  = overflow_q;
    if (accept && !release_blk) begin
      occupancy_d = occupancy_q + 3'd1;
    end else if (!accept && release_blk) begin
      occupancy_d = occupancy_q - 3'd1;
    end
    if (quantizer_block_done && !accept) begin
      overflow_d = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (occupancy_q != 3'd0) state_d = StSend;
      end
      StSend: begin
        if (encoder_ready && (counter_q == 6'd63)) state_d = StDrain;
      end
      StDrain: begin
        if (encoder_block_done) begin
          // Back-to-back into the next buffer when one is already waiting.
          state_d = (occupancy_d != 3'd0) ? StSend : StIdle;
`ifdef ENTROPY_RESTART_INTERVAL_EN
          if (last_in_mcu && interval_end) state_d = StRestart;
`endif
        end
      end
`ifdef ENTROPY_RESTART_INTERVAL_EN
      StRestart: begin
        if (restart_done) state_d = (occupancy_d != 3'd0) ? StSend : StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Zigzag counter, read pointer and block/MCU bookkeeping next-state.
  always_comb begin
    counter_d   = counter_q;
    readbuf_d   = readbuf_q;
    block_idx_d = block_idx_q;
`ifdef ENTROPY_RESTART_INTERVAL_EN
    mcu_cnt_d   = mcu_cnt_q;
`endif
    if ((state_q == StIdle) && (occupancy_q != 3'd0)) counter_d = 6'd0;
    if (issue) counter_d = counter_q + 6'd1;
    if (release_blk) begin
      counter_d   = 6'd0;
      readbuf_d   = (readbuf_q + 2'd1) & PTR_MASK;
      block_idx_d = last_in_mcu ? 4'd0 : block_idx_q + 4'd1;
`ifdef ENTROPY_RESTART_INTERVAL_EN
      if (last_in_mcu) mcu_cnt_d = interval_end ? '0 : mcu_cnt_q + MCU_W'(1);
`endif
    end
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      occupancy_q <= 3'd0;
      overflow_q  <= 1'b0;
      counter_q   <= 6'd0;
      readbuf_q   <= 2'd0;
      block_idx_q <= 4'd0;
`ifdef ENTROPY_RESTART_INTERVAL_EN
      mcu_cnt_q   <= '0;
`endif
    end else begin
      occupancy_q <= occupancy_d;
      overflow_q  <= overflow_d;
      counter_q   <= counter_d;
      readbuf_q   <= readbuf_d;
      block_idx_q <= block_idx_d;
`ifdef ENTROPY_RESTART_INTERVAL_EN
      mcu_cnt_q   <= mcu_cnt_d;
`endif
    end
  end

  // Beat flags trail the address by the one-cycle RAM read latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= issue;
      first_q <= issue && (counter_q == 6'd0);
      last_q  <= issue && (counter_q == 6'd63);
    end
  end

  // FSM / datapath outputs.
  always_comb begin
    coefficient_address = {readbuf_q, ZIGZAG[counter_q]};
    encoder_readbuf     = readbuf_q;
    quantizer_stall     = full;
    overflow_error      = overflow_q;
    coefficient_valid   = valid_q;
    coefficient_first   = first_q;
    coefficient_last    = last_q;
    if (block_idx_q < LUMA_END) begin
      component = 2'd0;
    end else if (block_idx_q < CB_END) begin
      component = 2'd1;
    end else begin
      component = 2'd2;
    end
`ifdef ENTROPY_RESTART_INTERVAL_EN
    restart_request = (state_q == StRestart);
`endif
  end

endmodule

// File: doc/entropy_coder_manager_fsm.md
Name: entropy_coder_manager_fsm

Overview:
- Scheduler between the quantizer output buffer ring and the run-length/Huffman entropy coder.
- Tracks how many quantized 8x8 blocks are waiting in the ring and reads each one out in zigzag order, one coefficient per cycle, under encoder flow control.
- Tags each block with its DC-predictor component and releases the buffer once the encoder finishes the block.
- Back-pressures the quantizer manager when all buffers are occupied.

Parameters:
- NUM_BUFFERS, 4: quantizer output buffers in the ring; must be a power of two ≤ 4 (2-bit pointers).
- LUMA_BLOCKS, 4: Y blocks per MCU, mapped to component 0.
- CHROMA_BLOCKS, 2: chroma blocks per MCU; the first half maps to component 1 (Cb), the second half to component 2 (Cr).
- RESTART_INTERVAL, 16: MCUs per restart interval (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- quantizer_block_done  in  1  one-cycle pulse: quantizer finished writing one block
- encoder_ready  in  1  encoder can accept a coefficient one cycle later
- encoder_block_done  in  1  one-cycle pulse: encoder has emitted the block's EOB/last code
- quantizer_stall  out  1  ring full; quantizer must not start another block
- coefficient_address  out  8  {encoder_readbuf, zigzag natural-order index}
- encoder_readbuf  out  2  buffer currently being read
- coefficient_valid  out  1  RAM data for the previous cycle's address is valid this cycle
- coefficient_first  out  1  with coefficient_valid: DC coefficient (zigzag 0)
- coefficient_last  out  1  with coefficient_valid: zigzag 63
- component  out  2  0=Y, 1=Cb, 2=Cr; held for the whole block
- overflow_error  out  1  sticky: block_done arrived while the ring was full

Behaviour:
- Reset: state IDLE, occupancy 0, encoder_readbuf 0, zigzag counter 0, mcu block index 0.
- Reset values of outputs: coefficient_address 0, coefficient_valid/first/last 0, component 0, quantizer_stall 0, overflow_error 0.
- Reset mid-block abandons the block; no pulses are emitted after reset.
- Occupancy counter (0..NUM_BUFFERS):
  - +1 on quantizer_block_done; −1 on buffer release.
  - Both in the same cycle: unchanged.
  - quantizer_stall = (occupancy == NUM_BUFFERS), combinational from the register.
  - block_done while full and no release that cycle: occupancy holds, overflow_error sets and stays set until reset.
- IDLE:
  - If occupancy > 0, go to SEND with zigzag counter 0.
  - component is computed from the mcu block index on entry.
- SEND:
  - Each cycle with encoder_ready=1, drive coefficient_address = {encoder_readbuf, ZIGZAG[counter]} and increment the counter.
  - With encoder_ready=0, the address holds and the counter holds.
  - ZIGZAG is the standard JPEG 64-entry zigzag-to-natural table (entry 2 = 8, entry 3 = 16, entry 63 = 63).
- Read latency is 1 cycle:
  - coefficient_valid is the registered value of (state==SEND && encoder_ready).
  - first/last are registered alongside valid, from counter 0 and counter 63.
  - The encoder must accept every valid beat; encoder_ready means "space for next cycle".
- After issuing counter 63, go to DRAIN (the last beat becomes valid on the next cycle).
- DRAIN:
  - Wait for encoder_block_done. On the pulse: release the buffer (occupancy −1), encoder_readbuf +1 mod NUM_BUFFERS, mcu block index +1.
  - The mcu block index wraps to 0 after LUMA_BLOCKS+CHROMA_BLOCKS−1.
  - Next state: SEND if occupancy after the update > 0 (back-to-back, no IDLE bubble), else IDLE.
- encoder_block_done outside DRAIN is ignored.
- quantizer_block_done is honoured in every state.

Optional Feature:
- ENTROPY_RESTART_INTERVAL_EN.
- When defined:
  - Add output restart_request (1 bit) and an MCU counter.
  - After the release of the last block of the RESTART_INTERVAL-th MCU, enter state RESTART instead of SEND/IDLE.
  - RESTART asserts restart_request until input restart_done pulses (port added under the same macro), then continues per the DRAIN exit rule.
  - The MCU counter resets to 0.
  - restart_request resets to 0.
- When undefined: no RESTART state, no restart ports, MCUs counted only modulo the batch.

Test Plan:
- Single block, encoder_ready held 1: one block_done pulse → SEND next cycle.
  - addresses {0,0},{0,1},{0,8},{0,16},... for 64 cycles, valid one cycle behind.
  - first on beat 0, last on beat 63.
  - After encoder_block_done: encoder_readbuf=1, occupancy 0, IDLE.
- Back-pressure: encoder_ready toggles 1,0,0,1 during SEND → address and counter hold on the low cycles; exactly 64 valid beats; no duplicated or missing zigzag index.
- Ring full: 4 block_done pulses with the encoder stalled → quantizer_stall=1. A 5th pulse sets overflow_error; occupancy stays 4.
- Simultaneous events: block_done and encoder_block_done in the same cycle with occupancy 2 → occupancy stays 2; next state SEND on the following buffer.
- Component tagging: 7 consecutive blocks → component sequence 0,0,0,0,1,2,0.
- Reset asserted mid-SEND at counter 30 → next cycle all outputs at reset values; occupancy 0; a subsequent block starts at buffer 0 with address {0,0}.
